// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: pad-input conditioning for the GPIO slave.
// Each bit goes through a 2-flop synchronizer and then its own debounce
// counter. When a bit's debounced level changes, a one-cycle rise or fall
// pulse is produced.
// Optional macro GPIO_DB_STICKY_EN adds edge_clr/edge_sts. These form a
// sticky per-bit edge-status register with write-1-to-clear, where set wins.
module gpio_in_debounce #(
    parameter int gpio_w = 8,
    parameter int db_cyc = 50000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [gpio_w-1:0] raw_in,
`ifdef GPIO_DB_STICKY_EN
    input  logic [gpio_w-1:0] edge_clr,
    output logic [gpio_w-1:0] edge_sts,
`endif
    output logic [gpio_w-1:0] gpi,
    output logic [gpio_w-1:0] rise,
    output logic [gpio_w-1:0] fall,
    output logic              changed
);

    // Counter width is derived from db_cyc. It is at least 1 bit wide, so that db_cyc=1 still elaborates.
    localparam int              cnt_w    = (db_cyc > 1) ? $clog2(db_cyc) : 1;
    localparam logic [cnt_w-1:0] CNT_LAST = cnt_w'(db_cyc - 1);

    logic [gpio_w-1:0] sync1_q;
    logic [gpio_w-1:0] sync2_q;
    logic [gpio_w-1:0] gpi_q,  gpi_d;
    logic [gpio_w-1:0] rise_q, rise_d;
    logic [gpio_w-1:0] fall_q, fall_d;
    logic              changed_q, changed_d;
    logic [gpio_w-1:0] accept;

    // Two-stage synchronizer. Only sync2_q is seen by the debounce logic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < gpio_w; gi++) begin : g_bit
            logic [cnt_w-1:0] cnt_q, cnt_d;
            logic             accept_bit;

            // Count consecutive samples that disagree with the accepted level.
            // A single agreeing sample restarts the count. The counter stops at
            // CNT_LAST, where it accepts the new level instead of wrapping.
            always_comb begin
                cnt_d      = '0;
                accept_bit = 1'b0;
                if (sync2_q[gi] != gpi_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        accept_bit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Per-bit debounce counter.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign accept[gi] = accept_bit;
        end
    endgenerate

    // An accepted bit flips its level. The edge direction comes from the new level.
    always_comb begin
        gpi_d     = gpi_q ^ accept;
        rise_d    = accept & sync2_q;
        fall_d    = accept & ~sync2_q;
        changed_d = |accept;
    end

    // Register the debounced level together with the edge pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpi_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            gpi_q     <= gpi_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign gpi     = gpi_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

`ifdef GPIO_DB_STICKY_EN
    logic [gpio_w-1:0] edge_sts_q, edge_sts_d;

    // A new edge on a bit sets its sticky status. A clear request on the same cycle loses to the set.
    always_comb begin
        edge_sts_d = (edge_sts_q & ~edge_clr) | rise_d | fall_d;
    end

    // Sticky edge-status register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_sts_q <= '0;
        end else begin
            edge_sts_q <= edge_sts_d;
        end
    end

    assign edge_sts = edge_sts_q;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Testbench for gpio_in_debounce (gpio_w=8, db_cyc=4).
// A window-based reference model runs alongside the DUT. On each edge it
// accepts a bit once the last DB synchronised samples all disagree with
// that bit's accepted level. Outputs are compared on every falling edge.
// Directed scenarios also check hand-computed literal values.
module tb_gpio_in_debounce;

    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] raw_in;
    logic [W-1:0] edge_clr;
    logic [W-1:0] gpi, rise, fall;
    logic         changed;
    logic [W-1:0] edge_sts;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    gpio_in_debounce #(.gpio_w(W), .db_cyc(DB)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .raw_in   (raw_in),
`ifdef GPIO_DB_STICKY_EN
        .edge_clr (edge_clr),
        .edge_sts (edge_sts),
`endif
        .gpi      (gpi),
        .rise     (rise),
        .fall     (fall),
        .changed  (changed)
    );

`ifndef GPIO_DB_STICKY_EN
    assign edge_sts = '0;
`endif

    // ---------------- reference model ----------------
    // hist holds raw samples still in flight through the 2-cycle sync delay.
    // win holds the most recent DB synchronised samples.
    logic [W-1:0] hist[$] = '{8'h00, 8'h00};
    logic [W-1:0] win[$];
    logic [W-1:0] gpi_m = '0, rise_m = '0, fall_m = '0, sts_m = '0;
    logic         chg_m = 1'b0;
    logic [W-1:0] s_m, acc_m;
    bit           all_diff;

    // Update the model on every clock edge and on reset assertion.
    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            hist   = '{8'h00, 8'h00};
            win.delete();
            gpi_m  = '0;
            rise_m = '0;
            fall_m = '0;
            chg_m  = 1'b0;
            sts_m  = '0;
        end else begin
            s_m = hist.pop_front();
            hist.push_back(raw_in);
            win.push_back(s_m);
            if (win.size() > DB) void'(win.pop_front());
            acc_m = '0;
            if (win.size() == DB) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (win[k]) if (win[k][b] == gpi_m[b]) all_diff = 1'b0;
                    acc_m[b] = all_diff;
                end
            end
            rise_m = acc_m & ~gpi_m;
            fall_m = acc_m & gpi_m;
            chg_m  = |acc_m;
            gpi_m  = gpi_m ^ acc_m;
`ifdef GPIO_DB_STICKY_EN
            sts_m  = (sts_m & ~edge_clr) | acc_m;
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, one line per transaction.
    initial forever begin
        @(negedge clk);
        $display("t=%0t rstn=%b raw=%02h gpi=%02h rise=%02h fall=%02h chg=%b sts=%02h",
                 $time, rstn, raw_in, gpi, rise, fall, changed, edge_sts);
        chk("model_gpi",     {24'h0, gpi},      {24'h0, gpi_m});
        chk("model_rise",    {24'h0, rise},     {24'h0, rise_m});
        chk("model_fall",    {24'h0, fall},     {24'h0, fall_m});
        chk("model_changed", {31'h0, changed},  {31'h0, chg_m});
`ifdef GPIO_DB_STICKY_EN
        chk("model_sts",     {24'h0, edge_sts}, {24'h0, sts_m});
`endif
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rstn     = 1'b0;
        raw_in   = '0;
        edge_clr = '0;
        step(3);
        chk("reset_gpi", {24'h0, gpi}, 32'h0);
        chk("reset_changed", {31'h0, changed}, 32'h0);

        // 1: idle after reset
        rstn = 1'b1;
        step(20);
        chk("s1_gpi", {24'h0, gpi}, 32'h0);

        // 2: single bit rise, visible after edge 5
        raw_in = 8'h01;
        step(5);
        chk("s2_gpi_early", {24'h0, gpi}, 32'h00);
        step(1);
        chk("s2_gpi", {24'h0, gpi}, 32'h01);
        chk("s2_rise", {24'h0, rise}, 32'h01);
        chk("s2_fall", {24'h0, fall}, 32'h00);
        chk("s2_changed", {31'h0, changed}, 32'h1);
        step(1);
        chk("s2_rise_gone", {24'h0, rise}, 32'h00);
        chk("s2_changed_gone", {31'h0, changed}, 32'h0);

`ifdef GPIO_DB_STICKY_EN
        // 6: sticky status holds until cleared; set wins over clear
        chk("s6_sts_set", {24'h0, edge_sts}, 32'h01);
        step(3);
        chk("s6_sts_hold", {24'h0, edge_sts}, 32'h01);
        edge_clr = 8'h01;
        step(1);
        edge_clr = 8'h00;
        chk("s6_sts_clr", {24'h0, edge_sts}, 32'h00);
`endif
        raw_in = 8'h00;
        step(8);
        chk("s2_gpi_back", {24'h0, gpi}, 32'h00);
`ifdef GPIO_DB_STICKY_EN
        edge_clr = 8'h01;
        step(1);
        edge_clr = 8'h00;
        raw_in = 8'h01;
        step(5);
        edge_clr = 8'h01;
        step(1);
        chk("s6_set_wins", {24'h0, edge_sts}, 32'h01);
        chk("s6_rise", {24'h0, rise}, 32'h01);
        step(1);
        chk("s6_clr_after", {24'h0, edge_sts}, 32'h00);
        edge_clr = 8'h00;
        raw_in = 8'h00;
        step(8);
`endif

        // 3: glitch of 3 cycles is rejected, then 5 stable cycles are accepted
        raw_in = 8'h08;
        step(3);
        raw_in = 8'h00;
        step(10);
        chk("s3_glitch_gpi", {24'h0, gpi}, 32'h00);
        raw_in = 8'h08;
        step(5);
        raw_in = 8'h00;
        step(1);
        chk("s3_gpi", {24'h0, gpi}, 32'h08);
        chk("s3_rise", {24'h0, rise}, 32'h08);
        step(10);
        chk("s3_gpi_back", {24'h0, gpi}, 32'h00);

        // 4: multi-bit rise then fall
        raw_in = 8'hA5;
        step(5);
        chk("s4_gpi_early", {24'h0, gpi}, 32'h00);
        step(1);
        chk("s4_gpi", {24'h0, gpi}, 32'hA5);
        chk("s4_rise", {24'h0, rise}, 32'hA5);
        chk("s4_changed", {31'h0, changed}, 32'h1);
        step(1);
        chk("s4_changed_gone", {31'h0, changed}, 32'h0);
        raw_in = 8'h00;
        step(6);
        chk("s4_fall", {24'h0, fall}, 32'hA5);
        chk("s4_gpi_low", {24'h0, gpi}, 32'h00);
        step(2);

        // 5: reset asserted mid-count
        raw_in = 8'h80;
        step(8);
        chk("s5_pre_gpi", {24'h0, gpi}, 32'h80);
        raw_in = 8'h81;
        step(4);
        #2 rstn = 1'b0;
        #1;
        chk("s5_async_gpi", {24'h0, gpi}, 32'h00);
        chk("s5_async_changed", {31'h0, changed}, 32'h0);
        @(negedge clk);
        rstn   = 1'b1;
        raw_in = 8'h01;
        step(5);
        chk("s5_gpi_early", {24'h0, gpi}, 32'h00);
        step(1);
        chk("s5_gpi", {24'h0, gpi}, 32'h01);
        chk("s5_rise", {24'h0, rise}, 32'h01);
        step(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
